// File: rtl/cpu_host_pkg.sv
// Shared definitions for the host-side loader: FSM encoding, memory strides and
// default memory depths.
package cpu_host_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_I  = 3'd1,
    LOAD_D  = 3'd2,
    CPU_RST = 3'd3,
    RUN     = 3'd4,
    RD_REQ  = 3'd5,
    RD_WAIT = 3'd6,
    RD_OUT  = 3'd7
  } state_t;

  localparam int IMEM_STRIDE    = 4;
  localparam int DMEM_STRIDE    = 8;
  localparam int DEF_IMEM_WORDS = 128;
  localparam int DEF_DMEM_WORDS = 128;

endpackage

// File: rtl/cpu_host_loader_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module loader_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_host_loader.sv
// Host controller that loads instruction/data memory from a word stream, resets
// and runs the core for a fixed cycle count, then streams back a dmem window.
module cpu_host_loader
  import cpu_host_pkg::*;
#(
  parameter int IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int DMEM_WORDS = DEF_DMEM_WORDS,
  parameter int CNT_W      = 32,
  parameter int RD_LAT     = 1,
  localparam int IW = $clog2(IMEM_WORDS) + 1,
  localparam int DW = $clog2(DMEM_WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IW-1:0]    n_instr,
  input  logic [DW-1:0]    n_din,
  input  logic [DW-2:0]    rd_base,
  input  logic [DW-1:0]    n_dout,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_arst_n,
  output logic             enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  input  logic [31:0]      rdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
);

  // Handshakes: a word moves on any rising edge where valid && ready are both
  // high; valid never waits on ready, and data is held while valid && !ready.

  localparam int WC_W  = (IW > DW) ? IW : DW;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  state_t state, next_state;

  logic [DW-1:0]    n_din_q, n_dout_q;
  logic [DW-2:0]    rd_base_q;
  logic [CNT_W-1:0] run_q;

  logic [IW-1:0] n_instr_c;
  logic [DW-1:0] n_din_c, n_dout_c, rd_room;

  logic [WC_W-1:0] idx;
  logic [DW-1:0]   rd_ptr;
  logic            in_fire, out_fire;

  logic            wc_load, wc_dec, wc_zero, wc_last;
  logic [WC_W-1:0] wc_val, wc_cnt;
  logic            rc_load, rc_dec, rc_zero, rc_last;
  logic [CNT_W-1:0] rc_cnt;
  logic            lc_load, lc_dec, lc_zero, lc_last;
  logic [LAT_W-1:0] lc_cnt;

  logic        wen_i_q, wen_d_q, arst_q, done_q;
  logic [63:0] waddr_i_q, waddr_d_q, wdata_d_q, out_data_q;
  logic [31:0] wdata_i_q;

  // Instruction memory is write-only from the host side.
  logic unused_ok;
  assign unused_ok = ^{rdata_ext, wc_zero, rc_zero};

  assign n_instr_c = (n_instr > IW'(IMEM_WORDS)) ? IW'(IMEM_WORDS) : n_instr;
  assign n_din_c   = (n_din > DW'(DMEM_WORDS)) ? DW'(DMEM_WORDS) : n_din;
  assign rd_room   = DW'(DMEM_WORDS) - DW'(rd_base);
  assign n_dout_c  = (n_dout > rd_room) ? rd_room : n_dout;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wc_last  = (wc_cnt == WC_W'(1));
  assign rc_last  = (rc_cnt == CNT_W'(1));
  assign lc_last  = lc_zero || (lc_cnt == LAT_W'(1));

  loader_counter #(.W(WC_W)) u_word_cnt (
    .clk(clk), .rst(rst), .load(wc_load), .load_val(wc_val), .dec(wc_dec),
    .count(wc_cnt), .zero(wc_zero)
  );

  loader_counter #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst), .load(rc_load), .load_val(run_q), .dec(rc_dec),
    .count(rc_cnt), .zero(rc_zero)
  );

  loader_counter #(.W(LAT_W)) u_lat_cnt (
    .clk(clk), .rst(rst), .load(lc_load), .load_val(LAT_W'(RD_LAT)), .dec(lc_dec),
    .count(lc_cnt), .zero(lc_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wc_load    = 1'b0;
    wc_val     = '0;
    wc_dec     = 1'b0;
    rc_load    = 1'b0;
    rc_dec     = 1'b0;
    lc_load    = 1'b0;
    lc_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          wc_load = 1'b1;
          if (n_instr_c != '0) begin
            next_state = LOAD_I;
            wc_val     = WC_W'(n_instr_c);
          end else if (n_din_c != '0) begin
            next_state = LOAD_D;
            wc_val     = WC_W'(n_din_c);
          end else begin
            next_state = CPU_RST;
          end
        end
      end
      LOAD_I: begin
        if (in_fire) begin
          wc_dec = 1'b1;
          if (wc_last) begin
            wc_load    = 1'b1;
            wc_val     = WC_W'(n_din_q);
            next_state = (n_din_q != '0) ? LOAD_D : CPU_RST;
          end
        end
      end
      LOAD_D: begin
        if (in_fire) begin
          wc_dec = 1'b1;
          if (wc_last) next_state = CPU_RST;
        end
      end
      CPU_RST: begin
        // The word counter is reused for the readback length from here on.
        rc_load = 1'b1;
        wc_load = 1'b1;
        wc_val  = WC_W'(n_dout_q);
        if (run_q != '0)         next_state = RUN;
        else if (n_dout_q != '0) next_state = RD_REQ;
        else                     next_state = IDLE;
      end
      RUN: begin
        rc_dec = 1'b1;
        if (rc_last) next_state = (n_dout_q != '0) ? RD_REQ : IDLE;
      end
      RD_REQ: begin
        lc_load    = 1'b1;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        lc_dec = 1'b1;
        if (lc_last) next_state = RD_OUT;
      end
      RD_OUT: begin
        if (out_fire) begin
          wc_dec     = 1'b1;
          next_state = wc_last ? IDLE : RD_REQ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == LOAD_I) || (state == LOAD_D);
    out_valid   = (state == RD_OUT);
    busy        = (state != IDLE);
    enable      = (state == RUN);
    cpu_arst_n  = arst_q && (state != CPU_RST);
    ren_ext     = 1'b0;
    ren_ext_2   = (state == RD_REQ);
    wen_ext     = wen_i_q;
    addr_ext    = waddr_i_q;
    wdata_ext   = wdata_i_q;
    wen_ext_2   = wen_d_q;
    wdata_ext_2 = wdata_d_q;
    addr_ext_2  = '0;
    if (wen_d_q) begin
      addr_ext_2 = waddr_d_q;
    end else if (state == RD_REQ) begin
      addr_ext_2 = 64'(rd_ptr) * 64'(DMEM_STRIDE);
    end
    out_data = out_data_q;
    done     = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_din_q    <= '0;
      n_dout_q   <= '0;
      rd_base_q  <= '0;
      run_q      <= '0;
      idx        <= '0;
      rd_ptr     <= '0;
      wen_i_q    <= 1'b0;
      waddr_i_q  <= '0;
      wdata_i_q  <= '0;
      wen_d_q    <= 1'b0;
      waddr_d_q  <= '0;
      wdata_d_q  <= '0;
      arst_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_din_q   <= n_din_c;
        n_dout_q  <= n_dout_c;
        rd_base_q <= rd_base;
        run_q     <= run_cycles;
      end
      if (state == IDLE) begin
        idx <= '0;
      end else if (in_fire) begin
        idx <= wc_last ? '0 : idx + WC_W'(1);
      end
      if (state == CPU_RST) begin
        rd_ptr <= DW'(rd_base_q);
      end else if (out_fire) begin
        rd_ptr <= rd_ptr + DW'(1);
      end
      // Write strobes are registered copies of the accepting handshake.
      wen_i_q   <= in_fire && (state == LOAD_I);
      waddr_i_q <= (in_fire && state == LOAD_I) ? 64'(idx) * 64'(IMEM_STRIDE) : '0;
      wdata_i_q <= (in_fire && state == LOAD_I) ? in_data[31:0] : '0;
      wen_d_q   <= in_fire && (state == LOAD_D);
      waddr_d_q <= (in_fire && state == LOAD_D) ? 64'(idx) * 64'(DMEM_STRIDE) : '0;
      wdata_d_q <= (in_fire && state == LOAD_D) ? in_data : '0;
      arst_q    <= 1'b1;
      done_q    <= (state != IDLE) && (next_state == IDLE);
      if (state == RD_WAIT && lc_last) begin
        out_data_q <= rdata_ext_2;
      end
    end
  end

endmodule
